// File: rtl/inst_stream_encoder.sv
// inst_stream_encoder: turns symbolic MIPS instruction requests into 32-bit
// machine words and writes them sequentially into instruction memory.
// The pseudo-instruction li expands into one or two words.
module inst_stream_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic {ST_IDLE, ST_EMIT2} state_t;

  typedef enum logic [3:0] {
    K_ADDU = 4'd0, K_SUBU = 4'd1, K_LW  = 4'd2, K_SW  = 4'd3,
    K_BEQ  = 4'd4, K_LUI  = 4'd5, K_JAL = 4'd6, K_JR  = 4'd7,
    K_ORI  = 4'd8, K_J    = 4'd9, K_LI  = 4'd10, K_NOP = 4'd11
  } kind_t;

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state, w_state;
  logic              r_im_we, w_im_we;
  logic [ADDR_W-1:0] r_im_addr, w_im_addr;
  logic [31:0]       r_im_wdata, w_im_wdata;
  logic [ADDR_W:0]   r_count, w_count;
  logic              r_full, w_full;
  logic              r_err, w_err;
  logic [31:0]       r_second, w_second;

  logic [31:0]       w_word0;
  logic [31:0]       w_word1;
  logic              w_two;
  logic              w_illegal;
  logic              w_accept;
  logic [ADDR_W:0]   w_count_inc;

  assign req_ready   = (r_state == ST_IDLE) && !r_full;
  assign w_accept    = req_valid && req_ready;
  assign w_count_inc = r_count + 1'b1;

  // Encode the current request into its first (and optional second) word.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_word0   = 32'h0;
    w_word1   = 32'h0;
    w_two     = 1'b0;
    w_illegal = 1'b0;
    case (req_kind)
      K_ADDU: w_word0 = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
      K_SUBU: w_word0 = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
      K_LW:   w_word0 = {6'b100011, rs, rt, imm[15:0]};
      K_SW:   w_word0 = {6'b101011, rs, rt, imm[15:0]};
      K_BEQ:  w_word0 = {6'b000100, rs, rt, imm[15:0]};
      K_LUI:  w_word0 = {6'b001111, 5'b00000, rt, imm[15:0]};
      K_JAL:  w_word0 = {6'b000011, imm[25:0]};
      K_JR:   w_word0 = {6'b000000, rs, 15'b0, 6'b001000};
      K_ORI:  w_word0 = {6'b001101, rs, rt, imm[15:0]};
      K_J:    w_word0 = {6'b000010, imm[25:0]};
      K_LI: begin
        if (imm[31:16] == 16'h0) begin
          w_word0 = {6'b001101, 5'b00000, rt, imm[15:0]};
        end else begin
          w_word0 = {6'b001111, 5'b00000, rt, imm[31:16]};
          w_word1 = {6'b001101, rt, rt, imm[15:0]};
          w_two   = (imm[15:0] != 16'h0);
        end
      end
      K_NOP:  w_word0 = 32'h0;
      default: w_illegal = 1'b1;
    endcase
  end

  // Next-state and next-output computation for the write sequencer.
  always_comb begin
    w_state    = r_state;
    w_im_we    = 1'b0;
    w_im_addr  = r_im_addr;
    w_im_wdata = r_im_wdata;
    w_count    = r_count;
    w_err      = r_err;
    w_second   = r_second;
    if (clear) begin
      // Restart wins over everything, including a pending second li word.
      w_state = ST_IDLE;
      w_count = '0;
      w_err   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              w_err = 1'b1;
            end else begin
              w_im_we    = 1'b1;
              w_im_addr  = r_count[ADDR_W-1:0];
              w_im_wdata = w_word0;
              w_count    = w_count_inc;
              if (w_two) begin
                // No room for the second li word: drop it and flag the loss.
                if (w_count_inc == CAP) begin
                  w_err = 1'b1;
                end else begin
                  w_state  = ST_EMIT2;
                  w_second = w_word1;
                end
              end
            end
          end
        end
        ST_EMIT2: begin
          w_im_we    = 1'b1;
          w_im_addr  = r_count[ADDR_W-1:0];
          w_im_wdata = r_second;
          w_count    = w_count_inc;
          w_state    = ST_IDLE;
        end
        default: w_state = ST_IDLE;
      endcase
    end
    w_full = (w_count == CAP);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_im_we    <= 1'b0;
      r_im_addr  <= '0;
      r_im_wdata <= 32'h0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_second   <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state;
      r_im_we    <= w_im_we;
      r_im_addr  <= w_im_addr;
      r_im_wdata <= w_im_wdata;
      r_count    <= w_count;
      r_full     <= w_full;
      r_err      <= w_err;
      r_second   <= w_second;
    end
  end

  assign im_we    = r_im_we;
  assign im_addr  = r_im_addr;
  assign im_wdata = r_im_wdata;
  assign count    = r_count;
  assign full     = r_full;
  assign err      = r_err;

endmodule
